// File: rtl/leaf_out_arbiter_if.sv
// Handshake bundle between the user kernel's output streams, the leaf
// output arbiter and the leaf's packet port towards the BFT.
interface leaf_out_arbiter_if #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_OUT_PORTS = 7
);
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user2arb;
  logic [NUM_OUT_PORTS-1:0]              vld_user2arb;
  logic [NUM_OUT_PORTS-1:0]              ack_arb2user;
  logic [PACKET_BITS-1:0]                dout_arb2bft;
  logic                                  dout_rdy;

  // Arbiter side: consumes user words, produces packets.
  modport slave (
    input  din_user2arb,
    input  vld_user2arb,
    input  dout_rdy,
    output ack_arb2user,
    output dout_arb2bft
  );

  // Environment side: user kernel plus BFT port.
  modport master (
    output din_user2arb,
    output vld_user2arb,
    output dout_rdy,
    input  ack_arb2user,
    input  dout_arb2bft
  );
endinterface

// File: rtl/leaf_out_arbiter.sv
// Leaf output arbiter: round-robin scheduling of the user output ports onto
// the single packet link, with per-port destination config, remote write
// address counters and credit (free remote slot) accounting.
module leaf_out_arbiter #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  leaf_out_arbiter_if.slave                    bus,
  input  logic                                 cfg_wr,
  input  logic [NUM_PORT_BITS-1:0]             cfg_port,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] cfg_dest,
  input  logic                                 credit_upd_vld,
  input  logic [NUM_PORT_BITS-1:0]             credit_upd_port,
  output logic                                 credit_err
);

  localparam int DEST_W = NUM_LEAF_BITS + NUM_PORT_BITS;
  // Credit counter holds 0..CMAX, so one bit wider than the address.
  localparam int CW = NUM_ADDR_BITS + 1;
  // Headroom for credit + update before saturation is decided.
  localparam int WW = NUM_ADDR_BITS + 3;

  localparam logic [CW-1:0]            CMAX   = CW'(1) << NUM_ADDR_BITS;
  localparam logic [WW-1:0]            CMAX_W = WW'(CMAX);
  localparam logic [WW-1:0]            UPD_W  = WW'(FREESPACE_UPDATE_SIZE);
  localparam logic [NUM_PORT_BITS:0]   NOUT   = (NUM_PORT_BITS+1)'(NUM_OUT_PORTS);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Credit result clipped to the remote buffer depth.
  function automatic logic [CW-1:0] sat_credit(input logic [WW-1:0] v);
    if (v > CMAX_W) return CMAX;
    else            return v[CW-1:0];
  endfunction

  // One-hot of the lowest set bit (all zero when v is zero).
  function automatic logic [NUM_OUT_PORTS-1:0] lowest_oh(input logic [NUM_OUT_PORTS-1:0] v);
    logic [NUM_OUT_PORTS-1:0] r;
    r = '0;
    for (int i = NUM_OUT_PORTS-1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  logic [0:0]               state_q, state_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic [NUM_PORT_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_OUT_PORTS-1:0] cfg_valid_q, cfg_valid_d;
  logic                     err_q, err_d;
  logic [CW-1:0]            credit_q [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_d [NUM_OUT_PORTS];
  logic [WW-1:0]            credit_sum [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_q [NUM_OUT_PORTS];
  logic [DEST_W-1:0]        dest_q [NUM_OUT_PORTS];

  logic [NUM_OUT_PORTS-1:0] elig;
  logic [NUM_OUT_PORTS-1:0] hi_mask;
  logic [NUM_OUT_PORTS-1:0] masked;
  logic [NUM_OUT_PORTS-1:0] grant_oh;
  logic [NUM_OUT_PORTS-1:0] ack;
  logic [NUM_OUT_PORTS-1:0] cfg_hit;
  logic [NUM_OUT_PORTS-1:0] upd_hit;
  logic                     load;
  logic                     cfg_in_range;
  logic                     upd_in_range;
  logic                     ovf_any;
  logic [PACKET_BITS-1:0]   pkt;

  assign cfg_in_range = ({1'b0, cfg_port} < NOUT);
  assign upd_in_range = ({1'b0, credit_upd_port} < NOUT);

  // Eligibility and the "at or above the pointer" window of the rotation.
  always_comb begin
    elig    = '0;
    hi_mask = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      elig[i]    = bus.vld_user2arb[i] & cfg_valid_q[i] & (credit_q[i] != '0);
      hi_mask[i] = (NUM_PORT_BITS'(i) >= rr_ptr_q);
    end
  end

  // Round-robin pick: first eligible at/after rr_ptr, otherwise wrap to the lowest.
  always_comb begin
    masked   = elig & hi_mask;
    grant_oh = (|masked) ? lowest_oh(masked) : lowest_oh(elig);
    load     = ((state_q == ST_EMPTY) | bus.dout_rdy) & (|elig);
    ack      = load ? grant_oh : '0;
  end

  assign bus.ack_arb2user = ack;
  assign bus.dout_arb2bft = dout_q;
  assign credit_err       = err_q;

  // Format the granted word and compute the pointer just past the grant.
  always_comb begin
    pkt      = '0;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant_oh[i]) begin
        pkt      = {1'b1, dest_q[i], addr_q[i], bus.din_user2arb[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
        rr_ptr_d = (i == NUM_OUT_PORTS-1) ? '0 : NUM_PORT_BITS'(i + 1);
      end
    end
  end

  // Output register state: load wins, a drained packet empties the register.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    if (load) begin
      state_d = ST_FULL;
      dout_d  = pkt;
    end else if ((state_q == ST_FULL) && bus.dout_rdy) begin
      state_d = ST_EMPTY;
      dout_d  = '0;
    end
  end

  // Decode of the config and credit-update port indices.
  always_comb begin
    cfg_hit = '0;
    upd_hit = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      cfg_hit[i] = cfg_wr & cfg_in_range & (cfg_port == NUM_PORT_BITS'(i));
      upd_hit[i] = credit_upd_vld & upd_in_range & (credit_upd_port == NUM_PORT_BITS'(i));
    end
    cfg_valid_d = cfg_valid_q | cfg_hit;
  end

  // Credit update: consume and refill both apply, then clip to CMAX.
  always_comb begin
    ovf_any = 1'b0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_sum[i] = WW'(credit_q[i]) - WW'(ack[i]) + (upd_hit[i] ? UPD_W : '0);
      credit_d[i]   = sat_credit(credit_sum[i]);
      if (credit_sum[i] > CMAX_W) ovf_any = 1'b1;
    end
    err_d = err_q | ovf_any | (credit_upd_vld & ~upd_in_range) | (cfg_wr & ~cfg_in_range);
  end

  // Control and output register; reset drops any held packet immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      dout_q      <= '0;
      rr_ptr_q    <= '0;
      cfg_valid_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      if (load) rr_ptr_q <= rr_ptr_d;
      cfg_valid_q <= cfg_valid_d;
      err_q       <= err_d;
    end
  end

  // Per-port credit counters and remote write-address counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= CMAX;
        addr_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= credit_d[i];
        if (ack[i]) addr_q[i] <= addr_q[i] + 1'b1;
      end
    end
  end

  // Destination table; only meaningful once the matching cfg_valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (cfg_hit[i]) dest_q[i] <= cfg_dest;
    end
  end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Bench for leaf_out_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level model of the scheduling rules.
module tb_leaf_out_arbiter;
  localparam int N   = 7;
  localparam int PB  = 32;
  localparam int PKB = 49;
  localparam int LB  = 5;
  localparam int PTB = 4;
  localparam int AB  = 7;
  localparam int CMAX = 1 << AB;
  localparam int UPD  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [N*PB-1:0]   din;
  logic [N-1:0]      vld;
  logic              rdy;
  logic              cfg_wr;
  logic [PTB-1:0]    cfg_port;
  logic [LB+PTB-1:0] cfg_dest;
  logic              upd_vld;
  logic [PTB-1:0]    upd_port;
  logic              credit_err;
  logic [N-1:0]      ack;
  logic [PKB-1:0]    dout;

  leaf_out_arbiter_if #(.PACKET_BITS(PKB), .PAYLOAD_BITS(PB), .NUM_OUT_PORTS(N)) bus ();

  assign bus.din_user2arb = din;
  assign bus.vld_user2arb = vld;
  assign bus.dout_rdy     = rdy;
  assign ack              = bus.ack_arb2user;
  assign dout             = bus.dout_arb2bft;

  leaf_out_arbiter u_dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus),
    .cfg_wr          (cfg_wr),
    .cfg_port        (cfg_port),
    .cfg_dest        (cfg_dest),
    .credit_upd_vld  (upd_vld),
    .credit_upd_port (upd_port),
    .credit_err      (credit_err)
  );

  // Reference model state
  bit              m_cfgv [N];
  int              m_dest [N];
  int              m_credit [N];
  int              m_addr [N];
  int              m_rr;
  bit              m_full;
  longint unsigned m_pkt;
  bit              m_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0]   obs_ack;
  logic [PKB-1:0] obs_dout;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      m_cfgv[p]   = 1'b0;
      m_credit[p] = CMAX;
      m_addr[p]   = 0;
    end
    m_rr   = 0;
    m_full = 1'b0;
    m_pkt  = 0;
    m_err  = 1'b0;
  endtask

  // First requesting, configured port with credit, rotating from the pointer.
  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_rr + k) % N;
      if (vld[p] && m_cfgv[p] && m_credit[p] > 0) return p;
    end
    return -1;
  endfunction

  task automatic model_update(input int g, input bit ld);
    for (int p = 0; p < N; p++) begin
      int c;
      c = m_credit[p];
      if (ld && g == p) c = c - 1;
      if (upd_vld && int'(upd_port) == p) c = c + UPD;
      if (c > CMAX) begin
        c     = CMAX;
        m_err = 1'b1;
      end
      m_credit[p] = c;
    end
    if (upd_vld && int'(upd_port) >= N) m_err = 1'b1;
    if (cfg_wr && int'(cfg_port) >= N)  m_err = 1'b1;
    if (ld) begin
      m_pkt = (64'd1 << 48) + (64'(m_dest[g]) << 39) + (64'(m_addr[g]) << 32)
            + 64'(din[g*PB +: PB]);
      m_addr[g] = (m_addr[g] + 1) % CMAX;
      m_rr      = (g + 1) % N;
      m_full    = 1'b1;
    end else if (m_full && rdy) begin
      m_full = 1'b0;
      m_pkt  = 0;
    end
    if (cfg_wr && int'(cfg_port) < N) begin
      m_cfgv[cfg_port] = 1'b1;
      m_dest[cfg_port] = int'(cfg_dest);
    end
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic cycle();
    int           g;
    bit           ld;
    logic [N-1:0] ea;
    #1;
    g  = model_grant();
    ld = (g >= 0) && (!m_full || rdy);
    ea = '0;
    if (ld) ea[g] = 1'b1;
    chk("ack", 64'(ack), 64'(ea));
    chk("dout", 64'(dout), m_pkt);
    chk("credit_err", 64'(credit_err), 64'(m_err));
    obs_ack  = ack;
    obs_dout = dout;
    model_update(g, ld);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    vld     = '0;
    rdy     = 1'b0;
    cfg_wr  = 1'b0;
    upd_vld = 1'b0;
    #1;
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_err", 64'(credit_err), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic rand_din();
    for (int p = 0; p < N; p++) din[p*PB +: PB] = $urandom;
  endtask

  task automatic cfg(input int port, input int leaf, input int dport);
    logic [LB-1:0]  l;
    logic [PTB-1:0] d;
    l        = LB'(leaf);
    d        = PTB'(dport);
    cfg_wr   = 1'b1;
    cfg_port = PTB'(port);
    cfg_dest = {l, d};
    cycle();
    cfg_wr = 1'b0;
  endtask

  int             cnt;
  int             first_addr;
  int             last_addr;
  int             pat [3] = '{0, 2, 6};
  logic [PKB-1:0] held;

  initial begin
    reset_n  = 1'b1;
    din      = '0;
    vld      = '0;
    rdy      = 1'b0;
    cfg_wr   = 1'b0;
    cfg_port = '0;
    cfg_dest = '0;
    upd_vld  = 1'b0;
    upd_port = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Credit exhaustion, refill and address wrap on port 0
    cfg(0, 3, 2);
    vld = 7'b0000001;
    rdy = 1'b1;
    cnt = 0;
    last_addr = -1;
    repeat (140) begin
      rand_din();
      cycle();
      cnt += int'(obs_ack[0]);
      if (obs_dout[48]) last_addr = int'(obs_dout[38:32]);
    end
    chk("exhaust_acks", 64'(cnt), 64'(CMAX));
    chk("exhaust_last_addr", 64'(last_addr), 64'(CMAX - 1));
    upd_vld  = 1'b1;
    upd_port = 4'd0;
    cycle();
    upd_vld = 1'b0;
    cnt = 0;
    first_addr = -1;
    last_addr  = -1;
    repeat (80) begin
      rand_din();
      cycle();
      cnt += int'(obs_ack[0]);
      if (obs_dout[48]) begin
        if (first_addr < 0) first_addr = int'(obs_dout[38:32]);
        last_addr = int'(obs_dout[38:32]);
      end
    end
    chk("refill_acks", 64'(cnt), 64'(UPD));
    chk("refill_first_addr", 64'(first_addr), 64'd0);
    chk("refill_last_addr", 64'(last_addr), 64'(UPD - 1));

    // Fairness among ports 0, 2, 6
    do_reset();
    cfg(0, 1, 1);
    cfg(2, 2, 2);
    cfg(6, 3, 3);
    vld = 7'b1000101;
    rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rand_din();
      cycle();
      chk("fair_grant", 64'(onehot_idx(obs_ack)), 64'(pat[i % 3]));
    end

    // Backpressure while FULL, then reload in the same cycle as ready
    rdy  = 1'b0;
    held = dout;
    chk("bp_full", 64'(held[48]), 64'd1);
    for (int i = 0; i < 5; i++) begin
      rand_din();
      cycle();
      chk("bp_stable", 64'(obs_dout), 64'(held));
      chk("bp_noack", 64'(obs_ack), 64'd0);
    end
    rdy = 1'b1;
    rand_din();
    cycle();
    chk("bp_reload", 64'(onehot_idx(obs_ack)), 64'd0);
    chk("bp_full_again", 64'(dout[48]), 64'd1);

    // Reset mid-packet, then saturation on port 1 with consume + update
    do_reset();
    cfg(1, 4, 5);
    vld      = 7'b0000010;
    rdy      = 1'b1;
    upd_vld  = 1'b1;
    upd_port = 4'd1;
    rand_din();
    cycle();
    upd_vld = 1'b0;
    chk("sat_ack", 64'(obs_ack), 64'h2);
    chk("sat_err", 64'(credit_err), 64'd1);
    cnt = 0;
    repeat (140) begin
      rand_din();
      cycle();
      cnt += int'(obs_ack[1]);
    end
    chk("sat_credit_drain", 64'(cnt), 64'(CMAX));

    // Unconfigured port requesting
    do_reset();
    vld = 7'b0010000;
    rdy = 1'b1;
    repeat (6) begin
      cycle();
      chk("unc_ack", 64'(obs_ack), 64'd0);
      chk("unc_dout", 64'(obs_dout), 64'd0);
    end

    // Out-of-range indices
    cfg_wr   = 1'b1;
    cfg_port = 4'd7;
    cycle();
    cfg_wr = 1'b0;
    chk("oor_cfg_err", 64'(credit_err), 64'd1);
    do_reset();
    upd_vld  = 1'b1;
    upd_port = 4'd9;
    cycle();
    upd_vld = 1'b0;
    chk("oor_upd_err", 64'(credit_err), 64'd1);

    // Randomized traffic against the model
    do_reset();
    for (int p = 0; p < N; p++) if ($urandom_range(0, 3) != 0) cfg(p, $urandom_range(0, 31), $urandom_range(0, 15));
    repeat (3000) begin
      rand_din();
      vld     = N'($urandom);
      rdy     = ($urandom_range(0, 3) != 0);
      cfg_wr  = ($urandom_range(0, 19) == 0);
      cfg_port = ($urandom_range(0, 99) == 0) ? PTB'($urandom_range(N, 15)) : PTB'($urandom_range(0, N-1));
      cfg_dest = (LB+PTB)'($urandom);
      upd_vld  = ($urandom_range(0, 9) == 0);
      upd_port = PTB'($urandom_range(0, N-1));
      cycle();
    end
    cfg_wr  = 1'b0;
    upd_vld = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
